// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed scan driver for an eight-digit seven-segment display.
//
// A 32-bit display word is scanned one hex nibble per refresh slot. Each slot opens with
// DEAD_CYCLES of forced blanking, then shows the digit unless leading-zero suppression hides it.
// New words are staged in a pending register and applied only at the frame boundary, so a frame
// is never torn.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   load         one-cycle strobe, captures data_in into the pending register
//   data_in      display word, nibble n drives digit n
//   lz_en        1 = blank leading zero digits
//   W,X,Y,Z      current nibble, W is the MSB
//   I,J,K        current digit index, I is the MSB
//   blank        1 = all digits off this cycle
//   frame_start  one-cycle pulse on the first cycle of the digit-0 slot
//   busy         1 = pending word not yet applied
module seg_scan_driver #(
  parameter int unsigned CLK_DIV     = 50000,
  parameter int unsigned DEAD_CYCLES = 2,
  parameter int unsigned NUM_DIGITS  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic        lz_en,
  output logic        W,
  output logic        X,
  output logic        Y,
  output logic        Z,
  output logic        I,
  output logic        J,
  output logic        K,
  output logic        blank,
  output logic        frame_start,
  output logic        busy
);

  localparam int unsigned PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] DeadEnd  = PW'(DEAD_CYCLES);
  localparam logic [2:0]    LastIdx  = 3'(NUM_DIGITS - 1);

  typedef enum logic {StDead, StShow} slot_state_e;

  slot_state_e    state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [2:0]     idx_q, idx_d;
  logic [31:0]    disp_q, disp_d;
  logic [31:0]    pend_q, pend_d;
  logic           pend_valid_q, pend_valid_d;
  logic [3:0]     nib_q, nib_d;
  logic           blank_q, blank_d;
  logic           frame_start_q, frame_start_d;

  logic           wrap;
  logic           boundary;
  logic [4:0]     shamt;
  logic [31:0]    tail;
  logic           suppress;

  always_comb begin
    wrap          = (presc_q == PrescMax);
    boundary      = wrap && (idx_q == LastIdx);
    presc_d       = wrap ? '0 : presc_q + PW'(1);
    idx_d         = wrap ? idx_q + 3'd1 : idx_q;

    // The boundary transfer uses the word that was pending before this edge; a coincident load
    // lands in pend_q and stays pending for the following frame.
    disp_d        = (boundary && pend_valid_q) ? pend_q : disp_q;
    pend_d        = load ? data_in : pend_q;
    pend_valid_d  = pend_valid_q;
    if (load) begin
      pend_valid_d = 1'b1;
    end else if (boundary) begin
      pend_valid_d = 1'b0;
    end

    state_d = state_q;
    unique case (state_q)
      StDead: if (presc_d >= DeadEnd) state_d = StShow;
      StShow: if (wrap && (DEAD_CYCLES != 0)) state_d = StDead;
      default: state_d = StDead;
    endcase

    // Nibbles at and above the next digit; all zero means this digit is a leading zero.
    shamt    = {idx_d, 2'b00};
    tail     = disp_d >> shamt;
    suppress = lz_en && (idx_d != 3'd0) && (tail == 32'd0);

    blank_d       = (state_d == StDead) || suppress;
    nib_d         = wrap ? tail[3:0] : nib_q;
    frame_start_d = boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StDead;
      presc_q       <= '0;
      idx_q         <= 3'd0;
      disp_q        <= 32'd0;
      pend_q        <= 32'd0;
      pend_valid_q  <= 1'b0;
      nib_q         <= 4'd0;
      blank_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      disp_q        <= disp_d;
      pend_q        <= pend_d;
      pend_valid_q  <= pend_valid_d;
      nib_q         <= nib_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign {W, X, Y, Z} = nib_q;
  assign {I, J, K}    = idx_q;
  assign blank        = blank_q;
  assign frame_start  = frame_start_q;
  assign busy         = pend_valid_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  localparam int unsigned CD    = 4;
  localparam int unsigned DC    = 1;
  localparam int unsigned FRAME = 8 * CD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [31:0] data_in = 32'd0;
  logic        lz_en = 1'b0;
  logic        W, X, Y, Z, I, J, K, blank, frame_start, busy;

  seg_scan_driver #(
    .CLK_DIV    (CD),
    .DEAD_CYCLES(DC),
    .NUM_DIGITS (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .data_in    (data_in),
    .lz_en      (lz_en),
    .W          (W),
    .X          (X),
    .Y          (Y),
    .Z          (Z),
    .I          (I),
    .J          (J),
    .K          (K),
    .blank      (blank),
    .frame_start(frame_start),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model: cycle count since reset release plus the display/pending words.
  int unsigned c = 0;
  logic [31:0] m_disp = 32'd0;
  logic [31:0] m_pend = 32'd0;
  bit          m_pv = 1'b0;
  bit          m_lz = 1'b0;

  function automatic logic [9:0] observed();
    return {W, X, Y, Z, I, J, K, blank, frame_start, busy};
  endfunction

  function automatic logic [9:0] expected();
    int unsigned digit = (c / CD) % 8;
    int unsigned pos   = c % CD;
    logic [31:0] tail  = m_disp >> (4 * digit);
    bit supp  = m_lz && (digit != 0) && (tail == 32'd0);
    bit blk   = (pos < DC) || supp;
    bit fs    = (c != 0) && (c % FRAME == 0);
    logic [3:0] nib = tail[3:0];
    logic [2:0] d3  = 3'(digit);
    return {nib, d3, blk, fs, m_pv};
  endfunction

  task automatic check_vec(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: cycle=%0d observed=%b expected=%b", tag, c, obs, exp);
  endtask

  // One clock: model consumes the inputs present at the edge, then outputs are checked 1ns later.
  task automatic tick(input string tag);
    @(posedge clk);
    c++;
    if ((c % FRAME == 0) && m_pv) begin
      m_disp = m_pend;
      m_pv   = 1'b0;
    end
    if (load) begin
      m_pend = data_in;
      m_pv   = 1'b1;
    end
    m_lz = lz_en;
    #1;
    check_vec(tag, observed(), expected());
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic do_load(input logic [31:0] w, input string tag);
    load    = 1'b1;
    data_in = w;
    tick(tag);
    load    = 1'b0;
  endtask

  initial begin
    logic [31:0] rw;

    // Reset values while held in reset.
    #12;
    check_vec("reset_hold", observed(), {4'h0, 3'h0, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_vec("reset_release", observed(), expected());

    // Basic scan with index-valued word; busy until the first boundary.
    do_load(32'h7654_3210, "scan_load");
    run(3 * FRAME, "scan");

    // Leading-zero suppression.
    lz_en = 1'b1;
    do_load(32'h0000_00A5, "lz_load_a5");
    run(2 * FRAME + 5, "lz_a5");
    do_load(32'h0000_0000, "lz_load_zero");
    run(2 * FRAME, "lz_zero");
    lz_en = 1'b0;
    run(FRAME, "lz_off");

    // Newest pending word wins; 0x11111111 never shown.
    while ((c % FRAME) != 3) tick("align_a");
    do_load(32'h1111_1111, "newest_first");
    run(10, "newest_mid");
    do_load(32'h2222_2222, "newest_second");
    run(2 * FRAME, "newest");

    // Load exactly on the boundary while another word is pending.
    do_load(32'hAAAA_AAAA, "bnd_pending");
    while (((c + 1) % FRAME) != 0) tick("align_b");
    do_load(32'h5555_5555, "bnd_coincide");
    run(2 * FRAME + 3, "bnd_after");

    // Randomized loads with varying leading zeros and lz_en toggles.
    for (int i = 0; i < 30 * FRAME; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        rw = $urandom;
        rw = rw >> (4 * $urandom_range(0, 8));
        load    = 1'b1;
        data_in = rw;
      end
      if ($urandom_range(0, 19) == 0) lz_en = 1'($urandom_range(0, 1));
      tick("random");
      load = 1'b0;
    end

    // Asynchronous reset mid-slot at digit 5, with a word pending.
    lz_en = 1'b0;
    do_load(32'hDEAD_BEEF, "ar_pending");
    while ((c % FRAME) != (5 * CD + 1)) tick("align_c");
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("async_reset", observed(), {4'h0, 3'h0, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    rst_n  = 1'b1;
    c      = 0;
    m_disp = 32'd0;
    m_pend = 32'd0;
    m_pv   = 1'b0;
    m_lz   = 1'b0;
    #1;
    check_vec("post_reset", observed(), expected());
    run(2 * FRAME, "post_reset_scan");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Time-multiplexed scan driver for the eight-digit seven-segment display. It holds a 32-bit display word and steps through its eight hex nibbles, one per refresh slot. For each slot it presents one nibble on W,X,Y,Z and the digit index on I,J,K. These feed the downstream hex/digit-select decoder directly. It also adds tear-free frame updates, inter-digit dead time and optional leading-zero blanking.

Parameters:
CLK_DIV, 50000, clock cycles per digit slot; legal range 2..2^20.
DEAD_CYCLES, 2, cycles at the start of each slot during which blank=1; must be < CLK_DIV.
NUM_DIGITS, 8, digits scanned; fixed at 8 because I,J,K is 3 bits.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
load  input  1  one-cycle strobe; capture data_in into the pending register.
data_in  input  32  display word; nibble n = data_in[4n+3:4n] drives digit n.
lz_en  input  1  1 = blank leading zero digits.
W  output  1  nibble bit 3 (MSB).
X  output  1  nibble bit 2.
Y  output  1  nibble bit 1.
Z  output  1  nibble bit 0 (LSB).
I  output  1  digit index bit 2 (MSB).
J  output  1  digit index bit 1.
K  output  1  digit index bit 0.
blank  output  1  1 = all digits must be off this cycle.
frame_start  output  1  one-cycle pulse at the first cycle of the digit-0 slot.
busy  output  1  1 = pending word not yet applied.

Behaviour:
- All outputs are registered. None of them has a combinational path from an input.
- Reset (rst_n=0, asynchronous):
  - prescaler=0, idx=0, disp_reg=0, pend_reg=0, pend_valid=0.
  - W..Z=0, I..K=000, blank=1, frame_start=0, busy=0.
  - Reset mid-slot or mid-frame discards any pending load.
- Prescaler:
  - Counts 0..CLK_DIV-1, then wraps to 0.
  - On wrap, idx advances by 1 and wraps 7 -> 0.
- Slot FSM, two states per slot:
  - DEAD: prescaler < DEAD_CYCLES; blank=1.
  - SHOW: remaining cycles; blank=0 unless the digit is suppressed.
  - DEAD -> SHOW when prescaler reaches DEAD_CYCLES.
  - SHOW -> DEAD on prescaler wrap.
- Output timing: I,J,K and W..Z change only at a slot boundary, i.e. the first DEAD cycle. They stay stable for the whole slot.
- Frame boundary is the cycle idx wraps 7 -> 0. On that cycle:
  - If pend_valid=1: disp_reg <= pend_reg, pend_valid <= 0.
  - frame_start=1, aligned with the first cycle of the digit-0 slot, with I..K=000 and the nibble taken from the newly applied word.
- Load handling:
  - load=1 sets pend_reg=data_in and pend_valid=1. It is accepted at any time.
  - A later load before the frame boundary overwrites the earlier one (newest wins).
  - If load coincides with the boundary cycle, the boundary transfer uses the old pend_reg. The new word becomes pending for the next frame, so pend_valid stays 1.
- busy = pend_valid (registered).
- Leading-zero suppression, when lz_en=1:
  - Digit n is suppressed if every nibble of disp_reg at index >= n is 0 and n != 0.
  - Digit 0 is never suppressed; a word of 0 shows a single "0".
  - A suppressed digit holds blank=1 for its whole slot. W..Z and I..K still sequence normally.
- lz_en is sampled each cycle. A change takes effect from the next SHOW cycle.
- The frame period is exactly 8*CLK_DIV cycles. No slot is ever skipped or stretched.

Test Plan:
1. CLK_DIV=4, DEAD_CYCLES=1; reset, load 0x76543210 -> busy=1 until the first frame boundary. From then, I,J,K = 0,1,...,7 every 4 cycles with W..Z equal to the index. blank=1 on prescaler=0 and 0 on 1..3. frame_start pulses every 32 cycles.
2. lz_en=1, word 0x000000A5 -> digits 0,1 show 5,A with blank=0 in SHOW. Digits 2..7 keep blank=1 for the full slot. Word 0x00000000 -> only digit 0 unblanked, W..Z=0000.
3. Load 0x11111111, then 0x22222222 mid-frame -> at the boundary disp_reg=0x22222222; 0x11111111 is never displayed.
4. Load on the exact boundary cycle while 0xAAAAAAAA is pending -> the next frame shows 0xAAAAAAAA, the new word is displayed one frame later, and busy stays 1 across the boundary.
5. Assert rst_n=0 asynchronously mid-slot at idx=5 -> outputs go to their reset values immediately, without a clock edge. After release, scanning restarts at idx=0, prescaler=0, with a display of 0.
6. Default parameters, long run of 10 frames -> every frame is exactly 400000 cycles, frame_start pulse count=10, and there is no glitch on I..K within a slot.
